div_n_fsm: RTL and testbench
============================

# div_n_fsm

Parametrised divide-by-N sequencer, the successor to the fixed divide-by-3 state machine. It generates a periodic enable waveform `y` from `clk`, and also produces a one-cycle end-of-period `tick`. The divisor and duty mode are programmable at run time; new settings apply glitch-free at the period boundary. The block feeds clock-enable and sampling-strobe inputs of downstream logic in the same clock domain.

## Interface
- `WIDTH`, default 8: divisor width; N ranges 0..2^WIDTH-1.
- `DEFAULT_DIV`, default 3: divisor after reset.
- `DEFAULT_MODE`, default 0: duty mode after reset (0 = pulse, 1 = square).

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; level-sensitive.
- `div_val`  in  WIDTH  requested divisor, sampled when `div_load`=1.
- `mode_val`  in  1  requested duty mode, sampled when `div_load`=1.
- `div_load`  in  1  single-cycle load strobe.
- `y`  out  1  divided waveform.
- `tick`  out  1  high on the last cycle of each period.
- `div_cur`  out  WIDTH  divisor currently in effect.
- `pend`  out  1  high while a loaded setting awaits its period boundary.

## Operation
- The FSM has two states:
  - IDLE: counter `cnt` = 0; `y` = 0; `tick` = 0.
  - RUN: `cnt` counts 0..Ne-1, then wraps to 0.
- Transitions:
  - IDLE to RUN when `en`=1 is sampled.
  - RUN to IDLE when `en`=0 is sampled; `cnt` clears to 0 at the same edge.
- Effective divisor Ne = max(`div_cur`, 1). A loaded 0 is stored as 0 in `div_cur` but behaves as 1.
- Decoding of `y` in RUN (combinational from registered state, no other inputs):
  - Pulse mode: `y` = (`cnt` == 0).
  - Square mode: `y` = (`cnt` < (Ne+1)>>1). For N=3 this gives 1,1,0; for N=4, 1,1,0,0.
- `tick` = RUN and (`cnt` == Ne-1). When Ne = 1, `tick` and `y` are both 1 on every RUN cycle.
- Load behaviour:
  - `div_load` captures `div_val` and `mode_val` into a pending register and sets `pend`.
  - In RUN, the pending setting transfers to active at the edge where `cnt` wraps (`tick`=1). `cnt` then restarts at 0 with the new Ne and mode, and `pend` clears.
  - In IDLE, the pending setting transfers at the next edge.
  - Repeated loads before transfer: the last load wins.
  - A load in the same cycle as a wrap goes to pending and transfers at the following wrap. The new value is never applied to the period that is just starting.
- Counter arithmetic is WIDTH bits with no overflow, because `cnt` ≤ Ne-1 ≤ 2^WIDTH-2.

## Timing
- Reset values: state IDLE, `cnt` = 0, `div_cur` = DEFAULT_DIV, active mode = DEFAULT_MODE, `pend` = 0, `y` = 0, `tick` = 0.
- `rst` has priority over all inputs; pending data is discarded.
- Latency from `en`:
  - `en` sampled 1 at edge k: state is RUN with `cnt` = 0 during cycle k+1, so `y` = 1 in cycle k+1.
  - `en` sampled 0 at edge k: `y` = 0 and `tick` = 0 from cycle k+1.
- Period is exactly Ne cycles while `en` stays high and no transfer occurs.
- `div_cur` and `pend` are registered:
  - They change at the transfer edge.
  - `pend` rises in the cycle after `div_load`.
- Toggling `en` mid-period aborts the period. The next RUN always starts at `cnt` = 0 and is not resumed.
- Outputs are glitch-free decodes of registers only; no input-to-output combinational path.

## Test plan
- Reset, then `en`=1 with defaults: `y` = 1,0,0,1,0,0…; `tick` = 0,0,1,0,0,1…; `div_cur` = 3.
- In RUN with N=3, load N=5 pulse at `cnt`=1: the current period finishes as 3 cycles, then `y` = 1,0,0,0,0 repeats; `pend` is high from load+1 until the wrap edge.
- Load N=4 mode=1, then N=5 mode=1: `y` = 1,1,0,0 repeating, then 1,1,1,0,0 repeating.
- Load N=0, then N=1: `y` = 1 and `tick` = 1 every RUN cycle in both cases; `div_cur` reads 0, then 1.
- Drop `en` at `cnt`=2 of N=5, hold low 3 cycles, raise again: `y` = 0 during IDLE; `y` = 1 one cycle after `en` is sampled 1, with a full 5-cycle period following.
- Assert `rst` with `pend`=1 mid-period: the next cycle shows IDLE, `div_cur` = 3, `pend` = 0, `y` = 0; the pending divisor is never applied.

Source files
------------

// File: rtl/div_n_fsm.sv
// div_n_fsm: programmable divide-by-N sequencer.
// Produces a periodic enable waveform y (pulse or square duty) and a one-cycle
// end-of-period tick. New divisor/mode settings are held pending and take
// effect only at a period boundary, so a running waveform never glitches.
module div_n_fsm #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 3,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             mode_val,
  input  logic             div_load,
  output logic             y,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic             mode_cur;
  logic [WIDTH-1:0] div_pend;
  logic             mode_pend;

  logic [WIDTH-1:0] ne;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH:0]   half;
  logic             xfer;

  // A stored divisor of 0 behaves as 1 so the counter always has a legal range.
  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
    return (d == '0) ? WIDTH'(1) : d;
  endfunction

  // Ceiling of n/2, one bit wider so n = 2^WIDTH-1 does not overflow.
  function automatic logic [WIDTH:0] ceil_half(input logic [WIDTH-1:0] n);
    return ({1'b0, n} + (WIDTH+1)'(1)) >> 1;
  endfunction

  // Output decode and transfer condition, from registered state only.
  always_comb begin
    ne       = eff_div(div_cur);
    last_cnt = ne - WIDTH'(1);
    half     = ceil_half(ne);
    tick     = (state == RUN) && (cnt == last_cnt);
    if (state != RUN) begin
      y = 1'b0;
    end else if (mode_cur) begin
      y = ({1'b0, cnt} < half);
    end else begin
      y = (cnt == '0);
    end
    // Pending settings move to active at a wrap, or at once when idle.
    xfer = pend && ((state == IDLE) || tick);
  end

  // Pending setting capture; validity is tracked by pend, so no reset needed.
  always_ff @(posedge clk) begin
    if (div_load) begin
      div_pend  <= div_val;
      mode_pend <= mode_val;
    end
  end

  // Run/idle state machine, period counter and active-setting transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= WIDTH'(DEFAULT_DIV);
      mode_cur <= DEFAULT_MODE;
      pend     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (tick) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (xfer) begin
        div_cur  <= div_pend;
        mode_cur <= mode_pend;
      end

      // A load coinciding with a transfer stays pending for the next boundary.
      if (div_load) begin
        pend <= 1'b1;
      end else if (xfer) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_n_fsm.sv
// Testbench for div_n_fsm: directed vector table followed by randomized
// stimulus compared against a behavioural period model.
module tb_div_n_fsm;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] div_val;
  logic         mode_val;
  logic         div_load;
  logic         y;
  logic         tick;
  logic [W-1:0] div_cur;
  logic         pend;

  int errors;
  int checks;

  div_n_fsm #(.WIDTH(W), .DEFAULT_DIV(3), .DEFAULT_MODE(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .mode_val (mode_val),
    .div_load (div_load),
    .y        (y),
    .tick     (tick),
    .div_cur  (div_cur),
    .pend     (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         r;
    logic         e;
    logic         l;
    logic [W-1:0] dv;
    logic         mv;
    logic         ey;
    logic         et;
    logic [W-1:0] ed;
    logic         ep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit e, input bit l, input int dv,
                              input bit mv, input bit ey, input bit et, input int ed,
                              input bit ep);
    vec_t v;
    v.r  = r;
    v.e  = e;
    v.l  = l;
    v.dv = W'(dv);
    v.mv = mv;
    v.ey = ey;
    v.et = et;
    v.ed = W'(ed);
    v.ep = ep;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input bit r, input bit e, input bit l, input int dv, input bit mv);
    rst      = r;
    en       = e;
    div_load = l;
    div_val  = W'(dv);
    mode_val = mv;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: position within the current period plus settings.
  int m_run, m_pos, m_n, m_mode, m_pv, m_pn, m_pm;

  function automatic int m_ne();
    return (m_n == 0) ? 1 : m_n;
  endfunction

  function automatic int m_y();
    if (m_run == 0) return 0;
    if (m_mode != 0) return (m_pos < (m_ne() + 1) / 2) ? 1 : 0;
    return (m_pos == 0) ? 1 : 0;
  endfunction

  function automatic int m_tick();
    return (m_run != 0 && m_pos == m_ne() - 1) ? 1 : 0;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit l, input int dv, input bit mv);
    int wrap;
    int take;
    if (r) begin
      m_run = 0; m_pos = 0; m_n = 3; m_mode = 0; m_pv = 0;
    end else begin
      wrap = m_tick();
      take = (m_pv != 0) && (m_run == 0 || wrap != 0);
      if (m_run == 0) begin
        m_pos = 0;
        m_run = e;
      end else if (!e) begin
        m_run = 0;
        m_pos = 0;
      end else begin
        m_pos = (wrap != 0) ? 0 : m_pos + 1;
      end
      if (take != 0) begin
        m_n = m_pn; m_mode = m_pm; m_pv = 0;
      end
      if (l) begin
        m_pn = dv; m_pm = mv; m_pv = 1;
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    mode_val = 1'b0;
    m_run = 0; m_pos = 0; m_n = 3; m_mode = 0; m_pv = 0; m_pn = 0; m_pm = 0;

    // r e l dv mv | y t div pend
    tbl.push_back(mk(1,0,0,0,0, 0,0,3,0)); // reset state
    tbl.push_back(mk(0,1,0,0,0, 1,0,3,0)); // defaults N=3 pulse
    tbl.push_back(mk(0,1,0,0,0, 0,0,3,0));
    tbl.push_back(mk(0,1,0,0,0, 0,1,3,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,3,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,3,0));
    tbl.push_back(mk(0,1,1,5,0, 0,1,3,1)); // load N=5 at cnt=1
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,1,5,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0));
    tbl.push_back(mk(0,1,1,4,1, 0,0,5,1)); // load N=4 square
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,1));
    tbl.push_back(mk(0,1,0,0,0, 0,1,5,1));
    tbl.push_back(mk(0,1,0,0,0, 1,0,4,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,4,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,4,0));
    tbl.push_back(mk(0,1,0,0,0, 0,1,4,0));
    tbl.push_back(mk(0,1,1,5,1, 1,0,4,1)); // load during wrap: deferred
    tbl.push_back(mk(0,1,0,0,0, 1,0,4,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,4,1));
    tbl.push_back(mk(0,1,0,0,0, 0,1,4,1));
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0)); // N=5 square 1,1,1,0,0
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,1,5,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,5,1)); // load N=0
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,1));
    tbl.push_back(mk(0,1,0,0,0, 0,1,5,1));
    tbl.push_back(mk(0,1,0,0,0, 1,1,0,0)); // N=0 acts as 1
    tbl.push_back(mk(0,1,1,1,0, 1,1,0,1)); // load N=1
    tbl.push_back(mk(0,1,0,0,0, 1,1,1,0));
    tbl.push_back(mk(0,1,1,5,0, 1,1,1,1)); // load N=5 pulse
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,5,0)); // drop en at cnt=2
    tbl.push_back(mk(0,0,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0)); // restart from cnt=0
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,0));
    tbl.push_back(mk(0,1,0,0,0, 0,1,5,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,5,0));
    tbl.push_back(mk(0,1,1,7,0, 0,0,5,1)); // load N=7, then reset
    tbl.push_back(mk(0,1,0,0,0, 0,0,5,1));
    tbl.push_back(mk(1,1,0,0,0, 0,0,3,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,3,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,3,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,3,0));
    tbl.push_back(mk(0,1,0,0,0, 0,1,3,0));
    tbl.push_back(mk(0,1,0,0,0, 1,0,3,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].l, int'(tbl[i].dv), tbl[i].mv);
      check("tbl.y",       i, int'(y),       int'(tbl[i].ey));
      check("tbl.tick",    i, int'(tick),    int'(tbl[i].et));
      check("tbl.div_cur", i, int'(div_cur), int'(tbl[i].ed));
      check("tbl.pend",    i, int'(pend),    int'(tbl[i].ep));
    end

    // Randomized run against the behavioural model.
    model_edge(1'b1, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      bit r, e, l, mv;
      int dv;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      l  = ($urandom_range(0, 19) == 0);
      mv = $urandom_range(0, 1);
      dv = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      model_edge(r, e, l, dv, mv);
      drive(r, e, l, dv, mv);
      check("rnd.y",       c, int'(y),       m_y());
      check("rnd.tick",    c, int'(tick),    m_tick());
      check("rnd.div_cur", c, int'(div_cur), m_n);
      check("rnd.pend",    c, int'(pend),    m_pv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
